// File: rtl/llc_output_encoder_pkg.sv
// Shared types and constants for the LLC outgoing-message encoder.
// Messages are buffered as llc_out_packet_t and steered onto one of four channels.
package llc_output_encoder_pkg;

    localparam int WORD_WIDTH         = 32;
    localparam int WORDS_PER_LINE     = 4;
    localparam int WORD_BITS          = $clog2(WORDS_PER_LINE);
    localparam int LLC_OUT_FIFO_DEPTH = 4;
    localparam int LINE_ADDR_BITS     = 28;
    localparam int COH_MSG_BITS       = 3;
    localparam int ID_BITS            = 4;

    // Memory requests always move whole lines as word-sized beats.
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef logic [WORD_WIDTH-1:0]                     word_t;
    typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_t;
    typedef logic [LINE_ADDR_BITS-1:0]                 line_addr_t;
    typedef logic [COH_MSG_BITS-1:0]                   coh_msg_t;
    typedef logic [ID_BITS-1:0]                        id_t;

    typedef enum logic [1:0] {
        KIND_RSP     = 2'd0,
        KIND_FWD     = 2'd1,
        KIND_DMA_RSP = 2'd2,
        KIND_MEM     = 2'd3
    } llc_out_kind_t;

    typedef enum logic {
        HEAD     = 1'b0,
        MEM_DATA = 1'b1
    } llc_enc_state_t;

    typedef struct packed {
        llc_out_kind_t kind;
        coh_msg_t      coh_msg;
        line_addr_t    addr;
        line_t         line;
        id_t           req_id;
        id_t           dest_id;
        logic          hprot;
        logic          hwrite;
    } llc_out_packet_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        line_addr_t addr;
        line_t      line;
        id_t        req_id;
        id_t        dest_id;
    } llc_rsp_out_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        line_addr_t addr;
        id_t        req_id;
        id_t        dest_id;
    } llc_fwd_out_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        line_addr_t addr;
        line_t      line;
        id_t        req_id;
    } llc_dma_rsp_out_t;

    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
        logic       hprot;
        line_addr_t addr;
    } llc_mem_req_t;

endpackage

// File: rtl/llc_output_encoder_fifo.sv
// In-order buffer of outgoing messages; the head entry is always visible.
// Push while full or pop while empty is prevented by the owner.
module llc_fifo_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int DEPTH = LLC_OUT_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  llc_out_packet_t push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output llc_out_packet_t head
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] PTR_ONE = (PTR_BITS + 1)'(1);

    llc_out_packet_t     mem [DEPTH];
    logic [PTR_BITS:0]   wr_ptr;
    logic [PTR_BITS:0]   rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_BITS-1:0]] <= push_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                   (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
    assign head  = mem[rd_ptr[PTR_BITS-1:0]];

endmodule

// File: rtl/llc_output_encoder.sv
// Drains buffered LLC messages onto the response, forward, DMA and memory channels;
// memory writes are sent as one header beat followed by one beat per line word.
module llc_output_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int DEPTH = LLC_OUT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_valid_in,
    input  llc_out_packet_t  out_packet_in,
    output logic             out_ready_in,
    output logic             llc_rsp_out_valid,
    input  logic             llc_rsp_out_ready,
    output llc_rsp_out_t     llc_rsp_out_data,
    output logic             llc_fwd_out_valid,
    input  logic             llc_fwd_out_ready,
    output llc_fwd_out_t     llc_fwd_out_data,
    output logic             llc_dma_rsp_out_valid,
    input  logic             llc_dma_rsp_out_ready,
    output llc_dma_rsp_out_t llc_dma_rsp_out_data,
    output logic             llc_mem_req_valid,
    input  logic             llc_mem_req_ready,
    output llc_mem_req_t     llc_mem_req_hdr,
    output logic             llc_mem_req_is_data,
    output word_t            llc_mem_req_word,
    output logic             idle
);

    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

    llc_enc_state_t        state, next_state;
    logic [WORD_BITS-1:0]  word_cnt, next_word_cnt;
    logic                  full, empty, push, pop, sel_ready, handshake;
    llc_out_packet_t       head;

    assign out_ready_in = !full && !rst;
    assign push         = out_valid_in && out_ready_in;

    llc_fifo_encoder #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (out_packet_in),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HEAD;
            word_cnt <= '0;
        end else begin
            state    <= next_state;
            word_cnt <= next_word_cnt;
        end
    end

    // Only the channel named by the head kind can complete a transfer.
    always_comb begin
        sel_ready = 1'b0;
        case (head.kind)
            KIND_RSP:     sel_ready = llc_rsp_out_ready;
            KIND_FWD:     sel_ready = llc_fwd_out_ready;
            KIND_DMA_RSP: sel_ready = llc_dma_rsp_out_ready;
            KIND_MEM:     sel_ready = llc_mem_req_ready;
            default:      sel_ready = 1'b0;
        endcase
    end

    assign handshake = !empty && sel_ready;

    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        next_state    = state;
        next_word_cnt = word_cnt;
        pop           = 1'b0;
        case (state)
            HEAD: begin
                if (handshake) begin
                    if (head.kind == KIND_MEM && head.hwrite) begin
                        next_state    = MEM_DATA;
                        next_word_cnt = '0;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            MEM_DATA: begin
                if (handshake) begin
                    if (word_cnt == LAST_WORD) begin
                        pop           = 1'b1;
                        next_word_cnt = '0;
                        next_state    = HEAD;
                    end else begin
                        next_word_cnt = word_cnt + WORD_BITS'(1);
                    end
                end
            end
            default: next_state = HEAD;
        endcase
    end

    always_comb begin
        llc_rsp_out_valid     = 1'b0;
        llc_fwd_out_valid     = 1'b0;
        llc_dma_rsp_out_valid = 1'b0;
        llc_mem_req_valid     = 1'b0;
        llc_mem_req_is_data   = 1'b0;
        llc_mem_req_word      = '0;
        if (!empty) begin
            if (state == MEM_DATA) begin
                llc_mem_req_valid   = 1'b1;
                llc_mem_req_is_data = 1'b1;
                llc_mem_req_word    = head.line[word_cnt];
            end else begin
                case (head.kind)
                    KIND_RSP:     llc_rsp_out_valid     = 1'b1;
                    KIND_FWD:     llc_fwd_out_valid     = 1'b1;
                    KIND_DMA_RSP: llc_dma_rsp_out_valid = 1'b1;
                    KIND_MEM:     llc_mem_req_valid     = 1'b1;
                    default:      llc_rsp_out_valid     = 1'b0;
                endcase
            end
        end
    end

    // Payloads follow the head entry, which is frozen until it is popped.
    assign llc_rsp_out_data = '{coh_msg: head.coh_msg, addr: head.addr, line: head.line,
                                req_id: head.req_id, dest_id: head.dest_id};
    assign llc_fwd_out_data = '{coh_msg: head.coh_msg, addr: head.addr,
                                req_id: head.req_id, dest_id: head.dest_id};
    assign llc_dma_rsp_out_data = '{coh_msg: head.coh_msg, addr: head.addr, line: head.line,
                                    req_id: head.req_id};
    assign llc_mem_req_hdr  = '{hwrite: head.hwrite, hsize: HSIZE_WORD, hprot: head.hprot,
                                addr: head.addr};

    assign idle = empty && (state == HEAD);

endmodule

// File: tb/tb_llc_output_encoder.sv
// Checks llc_output_encoder cycle by cycle against a queue-and-beat-index model
// through directed scenarios followed by a randomized phase.
module tb_llc_output_encoder;
    import llc_output_encoder_pkg::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             out_valid_in;
    llc_out_packet_t  out_packet_in;
    logic             out_ready_in;
    logic             llc_rsp_out_valid, llc_rsp_out_ready;
    llc_rsp_out_t     llc_rsp_out_data;
    logic             llc_fwd_out_valid, llc_fwd_out_ready;
    llc_fwd_out_t     llc_fwd_out_data;
    logic             llc_dma_rsp_out_valid, llc_dma_rsp_out_ready;
    llc_dma_rsp_out_t llc_dma_rsp_out_data;
    logic             llc_mem_req_valid, llc_mem_req_ready;
    llc_mem_req_t     llc_mem_req_hdr;
    logic             llc_mem_req_is_data;
    word_t            llc_mem_req_word;
    logic             idle;

    llc_output_encoder #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .out_valid_in          (out_valid_in),
        .out_packet_in         (out_packet_in),
        .out_ready_in          (out_ready_in),
        .llc_rsp_out_valid     (llc_rsp_out_valid),
        .llc_rsp_out_ready     (llc_rsp_out_ready),
        .llc_rsp_out_data      (llc_rsp_out_data),
        .llc_fwd_out_valid     (llc_fwd_out_valid),
        .llc_fwd_out_ready     (llc_fwd_out_ready),
        .llc_fwd_out_data      (llc_fwd_out_data),
        .llc_dma_rsp_out_valid (llc_dma_rsp_out_valid),
        .llc_dma_rsp_out_ready (llc_dma_rsp_out_ready),
        .llc_dma_rsp_out_data  (llc_dma_rsp_out_data),
        .llc_mem_req_valid     (llc_mem_req_valid),
        .llc_mem_req_ready     (llc_mem_req_ready),
        .llc_mem_req_hdr       (llc_mem_req_hdr),
        .llc_mem_req_is_data   (llc_mem_req_is_data),
        .llc_mem_req_word      (llc_mem_req_word),
        .idle                  (idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending messages in push order, plus how many beats of the head have gone.
    llc_out_packet_t q[$];
    int              beat = 0;
    logic [32:0]     mem_log[$];

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic llc_out_packet_t rand_pkt(input llc_out_kind_t kind, input logic hwrite);
        llc_out_packet_t p;
        p.kind    = kind;
        p.coh_msg = coh_msg_t'($urandom);
        p.addr    = line_addr_t'($urandom);
        for (int w = 0; w < WORDS_PER_LINE; w++) p.line[w] = $urandom;
        p.req_id  = id_t'($urandom);
        p.dest_id = id_t'($urandom);
        p.hprot   = 1'($urandom);
        p.hwrite  = hwrite;
        return p;
    endfunction

    function automatic logic head_ready(input llc_out_kind_t k);
        case (k)
            KIND_RSP:     return llc_rsp_out_ready;
            KIND_FWD:     return llc_fwd_out_ready;
            KIND_DMA_RSP: return llc_dma_rsp_out_ready;
            default:      return llc_mem_req_ready;
        endcase
    endfunction

    // A MEM write needs 1 + WORDS_PER_LINE accepted beats; everything else needs one.
    function automatic int beats_of(input llc_out_packet_t p);
        return (p.kind == KIND_MEM && p.hwrite) ? WORDS_PER_LINE + 1 : 1;
    endfunction

    task automatic model_update();
        bit do_push;
        if (rst) begin
            q.delete();
            beat = 0;
            return;
        end
        do_push = out_valid_in && (q.size() < DEPTH);
        if (q.size() > 0 && head_ready(q[0].kind)) begin
            beat++;
            if (beat == beats_of(q[0])) begin
                void'(q.pop_front());
                beat = 0;
            end
        end
        if (do_push) q.push_back(out_packet_in);
    endtask

    task automatic check_outputs();
        llc_out_packet_t h;
        llc_rsp_out_t     e_rsp;
        llc_fwd_out_t     e_fwd;
        llc_dma_rsp_out_t e_dma;
        llc_mem_req_t     e_hdr;
        logic             has;
        has = (q.size() > 0);
        h   = has ? q[0] : '0;
        check("out_ready_in", 200'(out_ready_in), 200'((q.size() < DEPTH) && !rst));
        check("idle", 200'(idle), 200'(!has));
        check("rsp_valid", 200'(llc_rsp_out_valid), 200'(has && h.kind == KIND_RSP));
        check("fwd_valid", 200'(llc_fwd_out_valid), 200'(has && h.kind == KIND_FWD));
        check("dma_valid", 200'(llc_dma_rsp_out_valid), 200'(has && h.kind == KIND_DMA_RSP));
        check("mem_valid", 200'(llc_mem_req_valid), 200'(has && h.kind == KIND_MEM));
        check("mem_is_data", 200'(llc_mem_req_is_data), 200'(has && beat > 0));
        check("mem_word", 200'(llc_mem_req_word),
              200'((has && beat > 0) ? h.line[beat-1] : word_t'(0)));
        if (has) begin
            case (h.kind)
                KIND_RSP: begin
                    e_rsp = '{coh_msg: h.coh_msg, addr: h.addr, line: h.line,
                              req_id: h.req_id, dest_id: h.dest_id};
                    check("rsp_data", 200'(llc_rsp_out_data), 200'(e_rsp));
                end
                KIND_FWD: begin
                    e_fwd = '{coh_msg: h.coh_msg, addr: h.addr, req_id: h.req_id,
                              dest_id: h.dest_id};
                    check("fwd_data", 200'(llc_fwd_out_data), 200'(e_fwd));
                end
                KIND_DMA_RSP: begin
                    e_dma = '{coh_msg: h.coh_msg, addr: h.addr, line: h.line, req_id: h.req_id};
                    check("dma_data", 200'(llc_dma_rsp_out_data), 200'(e_dma));
                end
                default: begin
                    e_hdr = '{hwrite: h.hwrite, hsize: HSIZE_WORD, hprot: h.hprot, addr: h.addr};
                    check("mem_hdr", 200'(llc_mem_req_hdr), 200'(e_hdr));
                end
            endcase
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic cycle();
        if (llc_mem_req_valid && llc_mem_req_ready && !rst)
            mem_log.push_back({llc_mem_req_is_data, llc_mem_req_word});
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_readys(input logic r);
        llc_rsp_out_ready     = r;
        llc_fwd_out_ready     = r;
        llc_dma_rsp_out_ready = r;
        llc_mem_req_ready     = r;
    endtask

    task automatic check_line_log(input string tag, input llc_out_packet_t p);
        check({tag, "_beats"}, 200'(mem_log.size()), 200'(WORDS_PER_LINE + 1));
        if (mem_log.size() == WORDS_PER_LINE + 1) begin
            check({tag, "_hdr_beat"}, 200'(mem_log[0]), 200'(33'd0));
            for (int w = 0; w < WORDS_PER_LINE; w++)
                check({tag, "_data_beat"}, 200'(mem_log[w+1]), 200'({1'b1, p.line[w]}));
        end
    endtask

    initial begin
        llc_out_packet_t p;
        int budget;

        rst = 1'b1;
        out_valid_in = 1'b0;
        out_packet_in = '0;
        set_readys(1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Three single-beat kinds back to back.
        set_readys(1'b1);
        out_valid_in = 1'b1;
        out_packet_in = rand_pkt(KIND_RSP, 1'b0);
        cycle();
        out_packet_in = rand_pkt(KIND_FWD, 1'b0);
        cycle();
        out_packet_in = rand_pkt(KIND_DMA_RSP, 1'b1);
        cycle();
        out_valid_in = 1'b0;
        repeat (3) cycle();

        // Full-line memory write with the memory always ready.
        mem_log.delete();
        p = rand_pkt(KIND_MEM, 1'b1);
        out_valid_in = 1'b1;
        out_packet_in = p;
        cycle();
        out_valid_in = 1'b0;
        repeat (6) cycle();
        check_line_log("mem_wr_full_rate", p);
        check("idle_after_mem_wr", 200'(idle), 200'(1'b1));

        // Memory ready toggling during the data beats.
        mem_log.delete();
        p = rand_pkt(KIND_MEM, 1'b1);
        out_valid_in = 1'b1;
        out_packet_in = p;
        cycle();
        out_valid_in = 1'b0;
        cycle();
        budget = 0;
        while (!idle && budget < 20) begin
            llc_mem_req_ready = ~llc_mem_req_ready;
            cycle();
            budget++;
        end
        check("mem_toggle_timeout", 200'(budget < 20), 200'(1'b1));
        llc_mem_req_ready = 1'b1;
        check_line_log("mem_wr_toggle", p);

        // Five pushes with nothing draining: the fifth is refused.
        set_readys(1'b0);
        for (int i = 0; i < 5; i++) begin
            out_valid_in = 1'b1;
            out_packet_in = rand_pkt(KIND_FWD, 1'b0);
            cycle();
            if (i == 3) check("not_ready_when_full", 200'(out_ready_in), 200'(1'b0));
        end
        out_valid_in = 1'b0;
        repeat (2) cycle();
        llc_fwd_out_ready = 1'b1;
        repeat (6) cycle();

        // Reset in the middle of a line transfer.
        set_readys(1'b1);
        out_valid_in = 1'b1;
        out_packet_in = rand_pkt(KIND_MEM, 1'b1);
        cycle();
        out_valid_in = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("idle_after_reset", 200'(idle), 200'(1'b1));
        check("mem_valid_after_reset", 200'(llc_mem_req_valid), 200'(1'b0));
        out_valid_in = 1'b1;
        out_packet_in = rand_pkt(KIND_RSP, 1'b0);
        cycle();
        out_valid_in = 1'b0;
        repeat (2) cycle();

        // Memory read: header only, then a response.
        out_valid_in = 1'b1;
        out_packet_in = rand_pkt(KIND_MEM, 1'b0);
        cycle();
        out_packet_in = rand_pkt(KIND_RSP, 1'b0);
        cycle();
        out_valid_in = 1'b0;
        repeat (3) cycle();

        // Randomized traffic, backpressure and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            llc_rsp_out_ready     = 1'($urandom);
            llc_fwd_out_ready     = 1'($urandom);
            llc_dma_rsp_out_ready = 1'($urandom);
            llc_mem_req_ready     = ($urandom_range(0, 3) != 0);
            out_valid_in = ($urandom_range(0, 9) < 6);
            out_packet_in = rand_pkt(llc_out_kind_t'($urandom_range(0, 3)), 1'($urandom));
            cycle();
        end
        rst = 1'b0;
        out_valid_in = 1'b0;
        set_readys(1'b1);
        repeat (30) cycle();
        check("idle_at_end", 200'(idle), 200'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/llc_output_encoder.md
LLC_OUTPUT_ENCODER -- requirements
Module: llc_output_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered outgoing-message entries (power of two, >= 2).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 out_valid_in  in  1  pipeline offers one outgoing message this cycle.
REQ-005 out_packet_in  in  llc_out_packet_t  kind, coh msg, line addr, line, req_id, dest_id, hprot, hwrite.
REQ-006 out_ready_in  out  1  buffer can accept; equals !full && !rst.
REQ-007 llc_rsp_out_valid / llc_rsp_out_ready / llc_rsp_out_data  out/in/out  1/1/llc_rsp_out_t  response to L2.
REQ-008 llc_fwd_out_valid / llc_fwd_out_ready / llc_fwd_out_data  out/in/out  1/1/llc_fwd_out_t  forward to L2.
REQ-009 llc_dma_rsp_out_valid / llc_dma_rsp_out_ready / llc_dma_rsp_out_data  out/in/out  1/1/llc_dma_rsp_out_t  DMA response.
REQ-010 llc_mem_req_valid / llc_mem_req_ready  out/in  1/1  memory request beat handshake.
REQ-011 llc_mem_req_hdr  out  llc_mem_req_t  hwrite, hsize, hprot, line addr; stable for every beat of a message.
REQ-012 llc_mem_req_is_data  out  1  0 = header beat, 1 = data beat.
REQ-013 llc_mem_req_word  out  word_t  data word of the current beat; 0 on header beats.
REQ-014 idle  out  1  buffer empty and FSM in HEAD.

Function
REQ-015 Push on out_valid_in && out_ready_in; when full, out_ready_in is 0 even if a pop occurs that cycle (no bypass).
REQ-016 Entries leave in push order; kind field (RSP=0, FWD=1, DMA_RSP=2, MEM=3) selects the sole channel whose valid may be high.
REQ-017 FSM states: HEAD, MEM_DATA.
REQ-018 HEAD, non-empty: assert valid of head kind; for MEM drive header beat (is_data=0).
REQ-019 HEAD handshake, kind RSP/FWD/DMA_RSP or MEM with hwrite=0: pop head, stay HEAD.
REQ-020 HEAD handshake, MEM with hwrite=1: no pop, word_cnt<=0, go MEM_DATA.
REQ-021 MEM_DATA: valid=1, is_data=1, word = line[word_cnt]; on handshake word_cnt++; on handshake with word_cnt==WORDS_PER_LINE-1 pop, word_cnt<=0, go HEAD.
REQ-022 Latency: message pushed at cycle N presents valid at N+1 if it reaches head; throughput one single-beat message per cycle.
REQ-023 Once valid is high, valid and all data/hdr/word outputs stay constant until the matching ready is sampled high.
REQ-024 Ready inputs of non-selected channels are ignored; a channel ready without its valid has no effect.
REQ-025 Simultaneous push and pop with non-full buffer: both occur, occupancy unchanged.
REQ-026 word_cnt width WORD_BITS; wraps only via REQ-021, never by overflow.

Reset
REQ-027 While rst is high at a clock edge: buffer empty, pointers 0, state HEAD, word_cnt 0.
REQ-028 After reset: all channel valids 0, is_data 0, word 0, idle 1, out_ready_in 1; a message in mid-transfer is discarded with no further beats.

Structure
REQ-029 llc_out_packet_t, llc_out_kind_t, llc_rsp_out_t, llc_fwd_out_t, llc_dma_rsp_out_t, llc_mem_req_t in cache_types.svh; WORDS_PER_LINE, WORD_BITS, LLC_OUT_FIFO_DEPTH in cache_consts.svh.
REQ-030 Buffer is one sub-module llc_fifo_encoder (push, pop, full, empty, head data); FSM, counter and channel steering live in llc_output_encoder.

Verification (WORDS_PER_LINE=4, DEPTH=4)
REQ-031 Push RSP, FWD, DMA_RSP on consecutive cycles, all readys=1 -> each valid exactly one cycle at N+1, N+2, N+3 in order.
REQ-032 Push MEM hwrite=1 line {A,B,C,D}, mem ready=1 -> beats hdr, A, B, C, D on 5 consecutive cycles, then idle=1.
REQ-033 Mem ready toggles 1,0,1,0 during data -> each word held while ready=0; no word lost or duplicated.
REQ-034 5 pushes with all readys=0 -> out_ready_in=0 after 4th, 5th not accepted, fwd valid held with constant data.
REQ-035 rst=1 during 2nd data beat -> next cycle all valids 0, idle=1; new RSP push delivered normally.
REQ-036 MEM hwrite=0 followed by RSP -> single header beat with is_data=0, then rsp valid next cycle.
